// File: rtl/mmu_bus_arb.sv
// Two-master bus arbiter (m0 = table walker, m1 = CPU) with cyc-locked ownership and a strobe timeout.
// Grant is one cycle after request; the bus then passes through combinationally. The waiting master is stalled with no response.
// MMU_ARB_RR_EN selects round-robin arbitration for simultaneous requests; the default build uses fixed m0 priority.
module mmu_bus_arb #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [1:0]  gnt_o,
    output logic        to_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       own_cyc;
    logic       own_stb;
    logic       tmo;
    logic       pick_m1;

`ifdef MMU_ARB_RR_EN
    logic       last_m1;
    // Simultaneous requests go to whichever master did not own the bus last.
    assign pick_m1 = m1_cyc_i && (!m0_cyc_i || !last_m1);
`else
    assign pick_m1 = m1_cyc_i && !m0_cyc_i;
`endif

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state)
            OWN0: begin
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
            end
            OWN1: begin
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
            end
            default: ;
        endcase
        // An ack landing on the timeout cycle completes the transfer normally.
        tmo = own_stb && (cnt == TIMEOUT) && !s_ack_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= 8'd0;
`ifdef MMU_ARB_RR_EN
            last_m1 <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (m0_cyc_i || m1_cyc_i) begin
                        state   <= pick_m1 ? OWN1 : OWN0;
`ifdef MMU_ARB_RR_EN
                        last_m1 <= pick_m1;
`endif
                    end
                end
                OWN0, OWN1: begin
                    if (!own_cyc) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (!own_stb || s_ack_i || s_err_i || (cnt == TIMEOUT)) begin
                        cnt <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 4'd0;
        s_adr_o = 32'd0;
        s_dat_o = 32'd0;
        case (state)
            OWN0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            OWN1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = (state == OWN0) && s_ack_i;
    assign m1_ack_o = (state == OWN1) && s_ack_i;
    assign m0_err_o = (state == OWN0) && (s_err_i || tmo);
    assign m1_err_o = (state == OWN1) && (s_err_i || tmo);
    assign to_o     = tmo;
    assign gnt_o    = {state == OWN1, state == OWN0};

endmodule

// File: tb/tb_mmu_bus_arb.sv
// Bench for mmu_bus_arb: directed vector table, arbitration-order sequence and randomized traffic against a cycle model.
module tb_mmu_bus_arb;
    localparam logic [7:0] TO = 8'd4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  gnt_o;
    logic        to_o;

    always #5 clk_i = ~clk_i;

    mmu_bus_arb #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o), .to_o(to_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: owner 0 = nobody, 1 = m0, 2 = m1; waited = strobe cycles spent without a response.
    int owner  = 0;
    int waited = 0;
    int last   = 1;

    typedef struct {
        logic [6:0]  in;   // {rst, c0, s0, c1, s1, ack, err}
        logic [31:0] d;
        logic [7:0]  exp;  // {gnt[1:0], a0, a1, e0, e1, to, s_cyc}
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string nm, input logic [141:0] act, input logic [141:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic model_tmo();
        logic stb;
        stb = (owner == 1) ? m0_stb_i : (owner == 2) ? m1_stb_i : 1'b0;
        return stb && (waited == int'(TO)) && !s_ack_i;
    endfunction

    function automatic logic [141:0] model_out();
        logic        c, s, w, t;
        logic [3:0]  sl;
        logic [31:0] a, d;
        logic [1:0]  g;
        {c, s, w, sl, a, d} = '0;
        g = 2'b00;
        if (owner == 1) begin
            {c, s, w, sl, a, d} = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
            g = 2'b01;
        end else if (owner == 2) begin
            {c, s, w, sl, a, d} = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
            g = 2'b10;
        end
        t = model_tmo();
        return {c, s, w, sl, a, d, s_dat_i, s_dat_i,
                owner == 2 && s_ack_i, owner == 1 && s_ack_i,
                owner == 2 && (s_err_i || t), owner == 1 && (s_err_i || t), g, t};
    endfunction

    task automatic model_update();
        logic t, cyc, stb;
        t = model_tmo();
        if (!rst_i) begin
            owner = 0; waited = 0; last = 1;
        end else if (owner == 0) begin
            if (m0_cyc_i && m1_cyc_i) begin
`ifdef MMU_ARB_RR_EN
                owner = (last == 1) ? 1 : 2;
`else
                owner = 1;
`endif
            end else if (m0_cyc_i) owner = 1;
            else if (m1_cyc_i) owner = 2;
            if (owner != 0) last = owner - 1;
            waited = 0;
        end else begin
            cyc = (owner == 1) ? m0_cyc_i : m1_cyc_i;
            stb = (owner == 1) ? m0_stb_i : m1_stb_i;
            if (!cyc) begin
                owner = 0; waited = 0;
            end else if (!stb || s_ack_i || s_err_i || t) waited = 0;
            else waited++;
        end
    endtask

    task automatic settle();
        @(negedge clk_i);
        check("model", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, m0_dat_o, m1_dat_o,
                        m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, gnt_o, to_o}, model_out());
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    function automatic vec_t mk(input logic [6:0] i, input logic [31:0] d, input logic [7:0] e);
        vec_t v;
        v.in = i; v.d = d; v.exp = e;
        return v;
    endfunction

    task automatic set_ctl(input logic r, input logic c0, input logic s0, input logic c1, input logic s1);
        {rst_i, m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = {r, c0, s0, c1, s1};
        {s_ack_i, s_err_i} = 2'b00;
    endtask

    logic [1:0] rr_exp [3];

    initial begin
        m0_we_i = 1'b0; m1_we_i = 1'b0; m0_sel_i = 4'hF; m1_sel_i = 4'hF;
        m0_adr_i = 32'h0000_0A00; m1_adr_i = 32'h0000_1000;
        m0_dat_i = 32'h1111_0000; m1_dat_i = 32'h2222_0000; s_dat_i = 32'd0;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();

        tbl.push_back(mk(7'b0_00_00_00, 32'h0,         8'b00_00_00_0_0));
        // m1 read with a response two cycles later (plus one bus error on the way)
        tbl.push_back(mk(7'b1_00_11_00, 32'h0,         8'b00_00_00_0_0));
        tbl.push_back(mk(7'b1_00_11_00, 32'h0,         8'b10_00_00_0_1));
        tbl.push_back(mk(7'b1_00_11_01, 32'h0,         8'b10_00_01_0_1));
        tbl.push_back(mk(7'b1_00_11_10, 32'hDEADBEEF,  8'b10_01_00_0_1));
        tbl.push_back(mk(7'b1_00_00_00, 32'h0,         8'b10_00_00_0_0));
        tbl.push_back(mk(7'b1_00_00_00, 32'h0,         8'b00_00_00_0_0));
        // simultaneous requests, m0 first, idle gap, then m1
        tbl.push_back(mk(7'b1_11_11_00, 32'h0,         8'b00_00_00_0_0));
        tbl.push_back(mk(7'b1_11_11_10, 32'h0,         8'b01_10_00_0_1));
        tbl.push_back(mk(7'b1_00_11_00, 32'h0,         8'b01_00_00_0_0));
        tbl.push_back(mk(7'b1_00_11_00, 32'h0,         8'b00_00_00_0_0));
        tbl.push_back(mk(7'b1_00_11_00, 32'h0,         8'b10_00_00_0_1));
        tbl.push_back(mk(7'b1_00_11_10, 32'h0,         8'b10_01_00_0_1));
        tbl.push_back(mk(7'b1_00_00_00, 32'h0,         8'b10_00_00_0_0));
        // timeout on the 5th unanswered strobe cycle, ownership kept
        tbl.push_back(mk(7'b1_11_00_00, 32'h0,         8'b00_00_00_0_0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(7'b1_11_00_00, 32'h0,     8'b01_00_00_0_1));
        tbl.push_back(mk(7'b1_11_00_00, 32'h0,         8'b01_00_10_1_1));
        tbl.push_back(mk(7'b1_11_00_00, 32'h0,         8'b01_00_00_0_1));
        tbl.push_back(mk(7'b1_00_00_00, 32'h0,         8'b01_00_00_0_0));
        tbl.push_back(mk(7'b1_00_00_00, 32'h0,         8'b00_00_00_0_0));
        // ack on the timeout cycle wins
        tbl.push_back(mk(7'b1_11_00_00, 32'h0,         8'b00_00_00_0_0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(7'b1_11_00_00, 32'h0,     8'b01_00_00_0_1));
        tbl.push_back(mk(7'b1_11_00_10, 32'h0,         8'b01_10_00_0_1));
        tbl.push_back(mk(7'b1_00_00_00, 32'h0,         8'b01_00_00_0_0));
        tbl.push_back(mk(7'b1_00_00_00, 32'h0,         8'b00_00_00_0_0));
        // reset mid-transfer, then m0 is granted first
        tbl.push_back(mk(7'b1_00_11_00, 32'h0,         8'b00_00_00_0_0));
        tbl.push_back(mk(7'b1_00_11_00, 32'h0,         8'b10_00_00_0_1));
        tbl.push_back(mk(7'b0_00_11_00, 32'h0,         8'b10_00_00_0_1));
        tbl.push_back(mk(7'b1_11_11_10, 32'h0,         8'b00_00_00_0_0));
        tbl.push_back(mk(7'b1_11_11_00, 32'h0,         8'b01_00_00_0_1));
        tbl.push_back(mk(7'b1_00_00_00, 32'h0,         8'b01_00_00_0_0));
        tbl.push_back(mk(7'b1_00_00_00, 32'h0,         8'b00_00_00_0_0));

        foreach (tbl[i]) begin
            {rst_i, m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i, s_err_i} = tbl[i].in;
            s_dat_i = tbl[i].d;
            settle();
            check($sformatf("vec%0d", i),
                  142'({gnt_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, to_o, s_cyc_o, m1_dat_o}),
                  142'({tbl[i].exp, tbl[i].d}));
            advance();
        end

        // three back-to-back simultaneous request pairs from reset
`ifdef MMU_ARB_RR_EN
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
`else
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b01; rr_exp[2] = 2'b01;
`endif
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle(); advance();
        for (int p = 0; p < 3; p++) begin
            set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            settle(); advance();
            settle();
            check($sformatf("pair%0d_gnt", p), 142'(gnt_o), 142'(rr_exp[p]));
            advance();
            set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            settle(); advance();
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_i = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(0, 7) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
            m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
            m0_we_i  = 1'($urandom);
            m1_we_i  = 1'($urandom);
            m0_sel_i = 4'($urandom);
            m1_sel_i = 4'($urandom);
            m0_adr_i = $urandom; m1_adr_i = $urandom;
            m0_dat_i = $urandom; m1_dat_i = $urandom;
            s_dat_i  = $urandom;
            s_ack_i  = ($urandom_range(0, 4) == 0);
            s_err_i  = ($urandom_range(0, 15) == 0);
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
